// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - MEM/WB register, result select, load extension, write gating, retire counter
module writeback_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        LoadTypeM,
  input  logic [REG_AW-1:0] RdM,
  input  logic [XLEN-1:0]   ALU_ResultM,
  input  logic [XLEN-1:0]   ReadDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   ImmExtM,
  output logic [XLEN-1:0]   ResultW,
  output logic [REG_AW-1:0] RdW,
  output logic              RegWriteW,
  output logic              ValidW,
  output logic              MisalignW,
  output logic [CNT_W-1:0]  InstRetW
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;
  localparam logic [1:0] SRC_IMM  = 2'b11;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic [1:0]        src_q,      src_d;
  logic [2:0]        ltype_q,    ltype_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic [XLEN-1:0]   alu_q,      alu_d;
  logic [XLEN-1:0]   rdata_q,    rdata_d;
  logic [XLEN-1:0]   pc4_q,      pc4_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  logic [CNT_W-1:0]  instret_q,  instret_d;

  logic [1:0]         off;
  logic [31:0]        lane;
  logic [31:0]        lane_shifted;
  logic signed [7:0]  load_byte;
  logic signed [15:0] load_half;
  logic signed [31:0] load_word;
  logic [XLEN-1:0]    load_ext;
  logic               is_byte;
  logic               is_half;
  logic               misalign;
  logic               retire;

  // Load alignment: pick the addressed byte/half from the low word and extend it
  always_comb begin
    off          = alu_q[1:0];
    lane         = rdata_q[31:0];
    lane_shifted = lane >> {off, 3'b000};
    load_byte    = lane_shifted[7:0];
    load_half    = off[1] ? lane[31:16] : lane[15:0];
    load_word    = lane;
    is_byte      = (ltype_q == LT_LB) || (ltype_q == LT_LBU);
    is_half      = (ltype_q == LT_LH) || (ltype_q == LT_LHU);
    case (ltype_q)
      LT_LB:   load_ext = XLEN'(load_byte);
      LT_LBU:  load_ext = XLEN'($unsigned(load_byte));
      LT_LH:   load_ext = XLEN'(load_half);
      LT_LHU:  load_ext = XLEN'($unsigned(load_half));
      default: load_ext = XLEN'(load_word);
    endcase
  end

  // Misalignment and write-enable qualification; unlisted funct3 behaves as a word load
  always_comb begin
    misalign = valid_q && (src_q == SRC_LOAD) &&
               ((is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00)));
    retire   = valid_q && !misalign;
  end

  // Result select from the registered W-stage fields
  always_comb begin
    case (src_q)
      SRC_ALU:  ResultW = alu_q;
      SRC_LOAD: ResultW = load_ext;
      SRC_PC4:  ResultW = pc4_q;
      SRC_IMM:  ResultW = imm_q;
      default:  ResultW = alu_q;
    endcase
  end

  // Next W-stage contents: flush beats stall, stall holds, otherwise capture M
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    src_d      = src_q;
    ltype_d    = ltype_q;
    rd_d       = rd_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    pc4_d      = pc4_q;
    imm_d      = imm_q;
    if (FlushW) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      src_d      = '0;
      ltype_d    = '0;
      rd_d       = '0;
      alu_d      = '0;
      rdata_d    = '0;
      pc4_d      = '0;
      imm_d      = '0;
    end else if (!StallW) begin
      valid_d    = ValidM;
      regwrite_d = RegWriteM;
      src_d      = ResultSrcM;
      ltype_d    = LoadTypeM;
      rd_d       = RdM;
      alu_d      = ALU_ResultM;
      rdata_d    = ReadDataM;
      pc4_d      = PCPlus4M;
      imm_d      = ImmExtM;
    end
    // A flush only kills the incoming instruction, so the retiring one still counts
    instret_d = instret_q;
    if (retire && !StallW) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // W-stage register and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      ltype_q    <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
      instret_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      src_q      <= src_d;
      ltype_q    <= ltype_d;
      rd_q       <= rd_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      pc4_q      <= pc4_d;
      imm_q      <= imm_d;
      instret_q  <= instret_d;
    end
  end

  assign RdW       = rd_q;
  assign ValidW    = valid_q;
  assign MisalignW = misalign;
  assign RegWriteW = valid_q && regwrite_q && (rd_q != '0) && !misalign;
  assign InstRetW  = instret_q;

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Parametrised successor of the single-stage writeback mux for the pipelined RISC-V core. Owns the MEM/WB pipeline register (with stall/flush), selects among four result sources, aligns and sign/zero-extends sub-word loads, detects misaligned loads, gates the register-file write, and keeps a retired-instruction counter. Sits between the data-memory stage and the register file / forwarding unit.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register address width.
- CNT_W, 64, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- StallW  in  1  hold the W-stage register.
- FlushW  in  1  load a bubble into the W-stage register.
- ValidM  in  1  M stage holds a real instruction.
- RegWriteM  in  1  instruction writes rd.
- ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4, 11 ImmExt (LUI).
- LoadTypeM  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- RdM  in  REG_AW  destination register.
- ALU_ResultM  in  XLEN  ALU result / load address.
- ReadDataM  in  XLEN  word-aligned memory read data.
- PCPlus4M  in  XLEN  PC+4.
- ImmExtM  in  XLEN  extended immediate.
- ResultW  out  XLEN  value written to rd; also forwarding source.
- RdW  out  REG_AW  registered rd.
- RegWriteW  out  1  qualified register-file write enable.
- ValidW  out  1  W stage holds a real instruction.
- MisalignW  out  1  W-stage load is misaligned.
- InstRetW  out  CNT_W  retired-instruction count.

## Operation
- W register captures all M inputs (ValidM, RegWriteM, ResultSrcM, LoadTypeM, RdM, four data buses).
- Update priority per edge: rst > FlushW > StallW > capture.
  - rst: every W register and InstRetW cleared to 0.
  - FlushW: ValidW and stored RegWrite cleared; other fields don't-care (implement as cleared). FlushW wins over simultaneous StallW.
  - StallW: all W fields hold.
- Result mux (combinational from W register): 00 ALU_ResultW, 01 LoadExt, 10 PCPlus4W, 11 ImmExtW.
- LoadExt: off = ALU_ResultW[1:0]; lane word = ReadDataW[31:0].
  - LB/LBU: byte at bits [8*off+7 : 8*off], sign-/zero-extended to XLEN.
  - LH/LHU: half at [16*off[1]+15 : 16*off[1]], sign-/zero-extended.
  - LW and any unlisted funct3: lane word sign-extended from bit 31 to XLEN (no-op when XLEN=32).
- MisalignW = ValidW & ResultSrcW==01 & ((half type & off[0]) | (word type & off!=0)). Byte loads never misalign.
- RegWriteW = ValidW & stored RegWrite & RdW!=0 & ~MisalignW.
- ResultW still driven for misaligned or x0 writes; only the enable is suppressed.
- InstRetW increments by 1 at an edge when ValidW & ~MisalignW & ~StallW & ~rst; FlushW does not block it (flush kills the incoming instruction, not the retiring one). Wraps from 2^CNT_W-1 to 0.

## Timing
- Latency: M inputs sampled at edge N appear on ResultW/RdW/RegWriteW after edge N (1 cycle); ResultW valid same cycle, combinational from register.
- Register file writes on the following edge; forwarding uses ResultW within the cycle.
- Reset values: ResultW 0, RdW 0, RegWriteW 0, ValidW 0, MisalignW 0, InstRetW 0.
- Reset asserted mid-stream: next edge clears state regardless of StallW/FlushW; the W instruction present at that edge is not counted.
- StallW held k cycles: outputs constant for k cycles, counter unchanged during them, counts once on release.
- Back-to-back captures without stall: one retirement per cycle.

## Test plan
- Reset: rst=1 one edge with StallW=1 and valid M inputs -> all outputs 0, InstRetW=0.
- Source select: ALU_ResultM=0x12345678 src 00, then ReadDataM=0xDEADBEEF LW off 0 src 01, then PCPlus4M=0x10 src 10, then ImmExtM=0xABCDE000 src 11, rd=5 each -> ResultW 0x12345678, 0xDEADBEEF, 0x10, 0xABCDE000 on consecutive cycles, RegWriteW=1, InstRetW 1..4.
- Sub-word loads, ReadDataM=0x80F17F01: LB off 3 -> 0xFFFFFF80; LBU off 3 -> 0x00000080; LH off 2 -> 0xFFFF80F1; LHU off 0 -> 0x00007F01; XLEN=64 LW -> 0xFFFFFFFF80F17F01.
- Misalign: LH off 1, LW off 2 -> MisalignW=1, RegWriteW=0, InstRetW unchanged; LB off 1 -> MisalignW=0.
- Hazards: StallW 3 cycles -> outputs frozen, counter frozen; FlushW with StallW -> ValidW=0, RegWriteW=0 next cycle, retiring W instruction counted; rd=0 -> RegWriteW=0 but counted.
- Wrap: CNT_W=4, 17 retirements -> InstRetW=1.
